// File: rtl/fib_pkg.sv
// Shared types and constants for the generalised-Fibonacci stream generator.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fib_state_t;

    localparam int FIB_WIDTH = 32;
    localparam int FIB_CNT_W = 8;

    localparam int unsigned FIB_SEED0   = 0;
    localparam int unsigned FIB_SEED1   = 1;
    localparam int unsigned LUCAS_SEED0 = 2;
    localparam int unsigned LUCAS_SEED1 = 1;

endpackage

// File: rtl/fib_core.sv
// Term datapath: holds the two most recent terms, the carry-producing adder
// and the per-term wrap bits.
module fib_core
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_advance,
    input  logic [WIDTH-1:0] i_seed0,
    input  logic [WIDTH-1:0] i_seed1,
    output logic [WIDTH-1:0] o_a,
    output logic             o_aw
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_aw;
    logic             r_bw;
    logic [WIDTH:0]   w_sum;

    // MSB of the widened sum is the carry out of the modular add.
    assign w_sum = {1'b0, r_a} + {1'b0, r_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a  <= '0;
            r_b  <= '0;
            r_aw <= 1'b0;
            r_bw <= 1'b0;
        end else if (i_load) begin
            r_a  <= i_seed0;
            r_b  <= i_seed1;
            r_aw <= 1'b0;
            r_bw <= 1'b0;
        end else if (i_advance) begin
            r_a  <= r_b;
            r_b  <= w_sum[WIDTH-1:0];
            r_aw <= r_bw;
            // A term built from a wrapped term is itself wrapped.
            r_bw <= w_sum[WIDTH] | r_aw | r_bw;
        end
    end

    assign o_a  = r_a;
    assign o_aw = r_aw;

endmodule

// File: rtl/fib_stream_gen.sv
// Generalised-Fibonacci term source with a valid/ready output stream,
// last-term flag, completion pulse and sticky wrap-around indication.
module fib_stream_gen
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH,
    parameter int CNT_W = FIB_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_terms,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    fib_state_t       r_state;
    fib_state_t       w_state_next;
    logic [CNT_W-1:0] r_remaining;
    logic             r_overflow;
    logic             w_accept;
    logic             w_handshake;
    logic             w_final;
    logic [WIDTH-1:0] w_a;
    logic             w_aw;

    assign w_accept    = (r_state == IDLE) && start;
    assign w_handshake = (r_state == RUN) && out_ready;
    assign w_final     = (r_remaining == CNT_W'(1));

    fib_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept),
        .i_advance (w_handshake),
        .i_seed0   (seed0),
        .i_seed1   (seed1),
        .o_a       (w_a),
        .o_aw      (w_aw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        out_valid    = 1'b0;
        out_data     = '0;
        out_last     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (n_terms != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                out_valid = 1'b1;
                out_data  = w_a;
                out_last  = w_final;
                busy      = 1'b1;
                if (out_ready && w_final) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
        end else if (w_accept) begin
            r_remaining <= n_terms;
        end else if (w_handshake) begin
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

    // Registered part keeps the flag after the wrapped term has left.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_overflow <= 1'b0;
        end else if ((r_state == RUN) && w_aw) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow | ((r_state == RUN) && w_aw);

endmodule

// File: tb/tb_fib_stream_gen.sv
// Randomised bench for fib_stream_gen: a 32-bit and an 8-bit instance run in
// lockstep against an unbounded-arithmetic reference of the term sequence.
module tb_fib_stream_gen;
    import fib_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        out_ready;
    logic [7:0]  n_terms;
    logic [31:0] seed0;
    logic [31:0] seed1;

    logic [31:0] d0_data;
    logic        d0_valid, d0_last, d0_busy, d0_done, d0_ovf;
    logic [7:0]  d1_data;
    logic        d1_valid, d1_last, d1_busy, d1_done, d1_ovf;

    always #5 clk = ~clk;

    fib_stream_gen #(.WIDTH(32), .CNT_W(8)) u_dut32 (
        .clk(clk), .rst(rst), .start(start), .n_terms(n_terms),
        .seed0(seed0), .seed1(seed1),
        .out_data(d0_data), .out_valid(d0_valid), .out_ready(out_ready),
        .out_last(d0_last), .busy(d0_busy), .done(d0_done), .overflow(d0_ovf)
    );

    fib_stream_gen #(.WIDTH(8), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .n_terms(n_terms),
        .seed0(seed0[7:0]), .seed1(seed1[7:0]),
        .out_data(d1_data), .out_valid(d1_valid), .out_ready(out_ready),
        .out_last(d1_last), .busy(d1_busy), .done(d1_done), .overflow(d1_ovf)
    );

    int total = 0;
    int bad   = 0;

    // Expected terms (modular) and whether the true term reached 2^WIDTH.
    longint unsigned m_data[2][256];
    bit              m_flag[2][256];

    task automatic check(input string tag, input longint unsigned got,
                         input longint unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic build(input int n, input longint unsigned s0, input longint unsigned s1);
        longint unsigned tru[256];
        for (int d = 0; d < 2; d++) begin
            int              w    = (d == 0) ? 32 : 8;
            longint unsigned cap  = 64'd1 << w;
            longint unsigned mask = cap - 1;
            for (int k = 0; k < n; k++) begin
                if (k == 0) begin
                    m_data[d][k] = s0 & mask;
                    tru[k]       = s0 & mask;
                end else if (k == 1) begin
                    m_data[d][k] = s1 & mask;
                    tru[k]       = s1 & mask;
                end else begin
                    m_data[d][k] = (m_data[d][k-1] + m_data[d][k-2]) % cap;
                    tru[k]       = tru[k-1] + tru[k-2];
                    if (tru[k] > cap) tru[k] = cap;
                end
                m_flag[d][k] = (tru[k] >= cap);
            end
        end
    endtask

    task automatic check_dut(input int d, input string ph, input bit ev,
                             input longint unsigned ed, input bit el,
                             input bit eb, input bit edn, input bit eo);
        string p = $sformatf("w%0d %s", (d == 0) ? 32 : 8, ph);
        if (d == 0) begin
            check({p, " valid"}, d0_valid, ev);
            check({p, " data"},  d0_data,  ed);
            check({p, " last"},  d0_last,  el);
            check({p, " busy"},  d0_busy,  eb);
            check({p, " done"},  d0_done,  edn);
            check({p, " ovf"},   d0_ovf,   eo);
        end else begin
            check({p, " valid"}, d1_valid, ev);
            check({p, " data"},  d1_data,  ed);
            check({p, " last"},  d1_last,  el);
            check({p, " busy"},  d1_busy,  eb);
            check({p, " done"},  d1_done,  edn);
            check({p, " ovf"},   d1_ovf,   eo);
        end
    endtask

    function automatic bit pick_ready(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
        return ($urandom % 2) == 1;
    endfunction

    // Entered and left at a negedge with the DUTs idle.
    task automatic run(input int n, input logic [31:0] s0, input logic [31:0] s1,
                       input int mode, input int rst_at);
        bit ovf_seen[2];
        int idx = 0;
        int cyc = 0;
        ovf_seen[0] = 1'b0;
        ovf_seen[1] = 1'b0;
        build(n, s0, s1);
        start     = 1'b1;
        n_terms   = 8'(n);
        seed0     = s0;
        seed1     = s1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seed0 = $urandom;
        seed1 = $urandom;
        while (idx < n) begin
            if (idx == rst_at) begin
                rst   = 1'b1;
                start = 1'b1;
                @(negedge clk);
                rst   = 1'b0;
                start = 1'b0;
                for (int d = 0; d < 2; d++) check_dut(d, "reset", 0, 0, 0, 0, 0, 0);
                $display("run n=%0d seeds=%0d,%0d reset at term %0d", n, s0, s1, idx);
                return;
            end
            for (int d = 0; d < 2; d++) begin
                check_dut(d, $sformatf("term%0d", idx), 1, m_data[d][idx], idx == n - 1,
                          1, 0, ovf_seen[d] | m_flag[d][idx]);
                ovf_seen[d] = ovf_seen[d] | m_flag[d][idx];
            end
            out_ready = pick_ready(mode, cyc);
            start     = ($urandom % 6) == 0;
            n_terms   = 8'($urandom);
            seed0     = $urandom;
            seed1     = $urandom;
            if (out_ready) idx++;
            cyc++;
            if (cyc > 4000) begin
                check("run_bound", cyc, 4000);
                break;
            end
            @(negedge clk);
        end
        for (int d = 0; d < 2; d++) check_dut(d, "done", 0, 0, 0, 1, 1, ovf_seen[d]);
        start = ($urandom % 2) == 1;
        @(negedge clk);
        start = 1'b0;
        for (int d = 0; d < 2; d++) check_dut(d, "idle", 0, 0, 0, 0, 0, ovf_seen[d]);
        $display("run n=%0d seeds=%0d,%0d mode=%0d cycles=%0d ovf32=%0d ovf8=%0d",
                 n, s0, s1, mode, cyc, ovf_seen[0], ovf_seen[1]);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        n_terms   = '0;
        seed0     = '0;
        seed1     = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) check_dut(d, "por", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_dut(d, "post_por", 0, 0, 0, 0, 0, 0);

        run(10, FIB_SEED0, FIB_SEED1, 0, -1);
        run(10, FIB_SEED0, FIB_SEED1, 1, -1);
        run(5, LUCAS_SEED0, LUCAS_SEED1, 0, -1);
        run(0, 32'd7, 32'd9, 0, -1);
        run(16, FIB_SEED0, FIB_SEED1, 0, -1);
        run(3, FIB_SEED0, FIB_SEED1, 0, -1);
        run(10, FIB_SEED0, FIB_SEED1, 0, 4);
        run(10, FIB_SEED0, FIB_SEED1, 0, -1);
        run(1, 32'd42, 32'd17, 2, -1);
        run(255, $urandom, $urandom, 2, -1);
        for (int r = 0; r < 25; r++) begin
            logic [31:0] s0 = ((r % 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            logic [31:0] s1 = ((r % 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            int          n  = $urandom_range(0, 40);
            int          ra = (($urandom % 5) == 0) ? $urandom_range(0, 40) : -1;
            run(n, s0, s1, $urandom_range(0, 2), ra);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
